// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
// Holds the FSM state encoding, the default frame width and the counter-width helper.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // A 1-bit counter is still needed when WIDTH collapses $clog2 to zero.
    function automatic int piso_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake plus serial output bundle of piso_shift_tx.
// master = word producer / serial consumer, slave = the transmitter.
interface piso_shift_tx_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output sout,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: counts 0..WIDTH-1 while enabled and wraps to 0 after the last bit.
// clear has priority over enable; last flags the final bit index combinationally.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH,
    localparam int CW   = piso_cnt_width(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          last
);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == LAST_IDX) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign last  = (r_count == LAST_IDX);

endmodule

// File: rtl/piso_shift_tx.sv
// MSB-first serializer of WIDTH-bit words, first bit 1 cycle after accept; PISO_TX_PARITY_EN appends even parity.
// load_ready is high in IDLE and on the final frame cycle, so held load_valid streams frames back to back.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    piso_shift_tx_if.slave    bus
);
    localparam int            CW      = piso_cnt_width(WIDTH);
    localparam logic [CW-1:0] MSB_IDX = CW'(WIDTH - 1);

    piso_state_e      r_state;
    piso_state_e      w_next;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_bit_idx;
    logic             w_last;
    logic             w_final;
    logic             w_ready;
    logic             w_accept;
    logic             w_sout;
    logic             w_sout_vld;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (r_state == SHIFT),
        .clear  (r_state != SHIFT),
        .count  (w_count),
        .last   (w_last)
    );

    // The held word is never shifted; the counter picks the bit, MSB first.
    assign w_bit_idx = MSB_IDX - w_count;

`ifdef PISO_TX_PARITY_EN
    assign w_final = (r_state == PARITY);
`else
    assign w_final = (r_state == SHIFT) && w_last;
`endif

    assign w_ready  = (r_state == IDLE) || w_final;
    assign w_accept = bus.load_valid && w_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= bus.load_data;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_sout     = 1'b0;
        w_sout_vld = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                w_sout_vld = 1'b1;
                w_sout     = r_data[w_bit_idx];
                if (w_last) begin
`ifdef PISO_TX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = w_accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                w_sout_vld = 1'b1;
                w_sout     = ^r_data;
                w_next     = w_accept ? SHIFT : IDLE;
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.load_ready = w_ready;
    assign bus.sout       = w_sout;
    assign bus.sout_valid = w_sout_vld;
    assign bus.busy       = w_sout_vld;
    assign bus.done       = w_final;

    a_done_in_frame: assert property (@(posedge clock) disable iff (reset)
        bus.done |-> (bus.busy && bus.sout_valid));

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboarded bench for piso_shift_tx: a frame-level model queues expected serial bits and a monitor checks them.
// Directed frames cover the key scenarios, then random traffic with occasional resets.
module tb_piso_shift_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    typedef struct packed {
        logic b;
        logic dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_rem  = 0;
    logic [7:0] rx_q   = '0;
    logic       acc;

    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(W)) bus();

    piso_shift_tx #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Serial-in receiver on the same clock, fed from the transmitter output.
    always @(posedge clk) rx_q <= {rx_q[6:0], bus.sout};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b  = d[i];
            e.dn = (FRAME == W) && (i == 0);
            sb.push_back(e);
        end
        if (FRAME > W) begin
            e.b  = ($countones(d) % 2) == 1;
            e.dn = 1'b1;
            sb.push_back(e);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance from its own frame occupancy.
    task automatic step(input logic v, input logic [W-1:0] d, output logic accepted);
        logic rdy;
        @(negedge clk);
        rdy = (m_rem <= 1);
        chk("load_ready", bus.load_ready, rdy);
        bus.load_valid = v;
        bus.load_data  = d;
        accepted = v && rdy;
        if (accepted) begin
            push_frame(d);
            m_rem = FRAME;
        end else if (m_rem > 0) begin
            m_rem--;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), a);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        bus.load_valid = 1'b0;
        sb.delete();
        m_rem = 0;
        #1;
        chk("rst_sout_valid", bus.sout_valid, 0);
        chk("rst_sout", bus.sout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_load_ready", bus.load_ready, 1);
        repeat (n) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("mon_rst_valid", bus.sout_valid, 0);
                chk("mon_rst_ready", bus.load_ready, 1);
            end else if (bus.sout_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got sout_valid 1 expected 0 at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sout", bus.sout, e.b);
                    chk("done", bus.done, e.dn);
                    chk("busy", bus.busy, 1);
                end
            end else begin
                chk("idle_sout", bus.sout, 0);
                chk("idle_busy", bus.busy, 0);
                chk("idle_done", bus.done, 0);
                chk("gap", sb.size(), 0);
            end
        end
    end

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        do_reset(3);
        idle(2);

        step(1'b1, 8'hA5, acc);
        idle(12);

        step(1'b1, 8'hFF, acc);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, 8'h00, acc);
        chk("b2b_second_accept", acc, 1);
        idle(12);

        step(1'b1, 8'hC3, acc);
        idle(4);
        do_reset(2);
        step(1'b1, 8'h81, acc);
        idle(12);

        step(1'b1, 8'h5A, acc);
        idle(3);
        step(1'b1, 8'hFF, acc);
        idle(12);

        step(1'b1, 8'h07, acc);
        idle(12);
        step(1'b1, 8'h03, acc);
        idle(12);

        step(1'b1, 8'h3C, acc);
        idle(9);
        chk("loopback_q", rx_q, 8'h3C);
        idle(4);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                step($urandom_range(0, 3) != 0, W'($urandom), acc);
            end
        end

        idle(15);
        chk("drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 SHALL have parameter: WIDTH, 8, frame data width in bits (legal range 2..32).
REQ-002 SHALL have port: clock  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: load_valid  input  1  producer offers load_data.
REQ-005 SHALL have port: load_ready  output  1  block accepts load_data this cycle.
REQ-006 SHALL have port: load_data  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port: sout  output  1  serial data, MSB first.
REQ-008 SHALL have port: sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 SHALL have port: busy  output  1  frame in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on the final bit of a frame.

Function
REQ-011 SHALL accept a word on any rising clock edge where load_valid and load_ready are both 1.
REQ-012 SHALL hold load_data stable internally once accepted; later load_data changes SHALL have no effect on the frame.
REQ-013 SHALL drive sout = load_data[WIDTH-1] with sout_valid=1 in the cycle after acceptance, then bits WIDTH-2 down to 0 on consecutive cycles; latency is 1 cycle and the data phase lasts WIDTH cycles.
REQ-014 SHALL use FSM states IDLE and SHIFT, plus PARITY when configured: IDLE->SHIFT on acceptance; SHIFT->IDLE after bit 0 when there is no parity; SHIFT->PARITY after bit 0 when parity is enabled; PARITY->IDLE after one cycle.
REQ-015 SHALL use a bit counter of width clog2(WIDTH) that counts 0..WIDTH-1 in SHIFT and wraps to 0 on the SHIFT exit.
REQ-016 SHALL drive load_ready = 1 in IDLE and in the final bit cycle of a frame; back-to-back acceptance SHALL produce gapless sout_valid with no idle bit between frames.
REQ-017 SHALL assert done for exactly the final bit cycle of each frame, with busy=1 in that cycle.
REQ-018 SHALL drive busy = 1 whenever sout_valid = 1 and 0 otherwise.
REQ-019 SHALL drive sout = 0 while sout_valid = 0.
REQ-020 SHALL ignore load_valid while load_ready = 0; a held load_valid SHALL be accepted at the next ready cycle.
REQ-021 SHALL, with an MSB-first input fed to the team's serial-in shift_8b receiver on the same clock, leave that receiver's q equal to the sent word WIDTH cycles after the first sout_valid cycle (WIDTH=8, no parity).

Reset
REQ-022 SHALL, on reset assertion, immediately drive sout=0, sout_valid=0, busy=0, done=0 and load_ready=1 (during reset), and set the FSM to IDLE and the counter and shift register to 0.
REQ-023 SHALL, on reset mid-frame, abort the frame with no completion and no done pulse; the first edge after deassertion SHALL be able to accept a new word.

Configuration
REQ-024 SHALL, when macro PISO_TX_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) after bit 0, giving a frame of WIDTH+1 valid cycles, with done and load_ready on the parity cycle.
REQ-025 SHALL, without PISO_TX_PARITY_EN, omit the PARITY state entirely, giving a frame of WIDTH cycles.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, SHIFT, PARITY) and the default WIDTH constant in shared package piso_pkg.
REQ-027 SHALL implement the bit counter as sub-module piso_bit_counter (inputs: clock, reset, enable, clear; outputs: count, last).

Verification
REQ-028 SHALL cover: WIDTH=8, load 8'hA5 in IDLE -> sout 1,0,1,0,0,1,0,1 on cycles 1..8, done on cycle 8 only, then idle.
REQ-029 SHALL cover: back-to-back 8'hFF then 8'h00 with load_valid held -> 16 contiguous sout_valid cycles, sout eight 1s then eight 0s, two done pulses.
REQ-030 SHALL cover: reset pulse after bit 3 of 8'hC3 -> sout_valid falls to 0 immediately, no done; a new 8'h81 then transmits cleanly.
REQ-031 SHALL cover: PISO_TX_PARITY_EN, 8'h07 -> 8 data bits then parity 1 on cycle 9, done on cycle 9; 8'h03 -> parity 0.
REQ-032 SHALL cover: load_valid pulsed during SHIFT at a non-final bit -> ignored, and the frame is unchanged.
REQ-033 SHALL cover: loopback into shift_8b, 8'h3C -> receiver q == 8'h3C eight cycles after the first sout_valid.
